// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared MIPS core types and the ID/EX latch record
package cpu_types_pkg;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    BEQ   = 6'b000100,
    BNE   = 6'b000101,
    ADDIU = 6'b001001,
    ORI   = 6'b001101,
    LUI   = 6'b001111,
    LW    = 6'b100011,
    SW    = 6'b101011,
    HALT  = 6'b111111
  } opcode_t;

  typedef enum logic [5:0] {
    SLL  = 6'b000000,
    SRL  = 6'b000010,
    JR   = 6'b001000,
    ADDU = 6'b100001,
    SUBU = 6'b100011,
    AND  = 6'b100100,
    OR   = 6'b100101
  } funct_t;

  typedef struct packed {
    logic     valid;
    opcode_t  op;
    funct_t   funct;
    regbits_t rs;
    regbits_t rt;
    regbits_t wsel;
    logic     regwrite;
    logic     memread;
    logic     memwrite;
    logic     halt;
    word_t    imm;
    word_t    rdat1;
    word_t    rdat2;
    word_t    npc;
  } id_ex_t;

  // sll $0,$0,0 with no side effects; never matches a forwarding source
  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at its maximum value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (!nRST)
      count <= '0;
    else if (en && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/id_ex_latch.sv
// rtl/id_ex_latch.sv - ID/EX pipeline register with bubble insertion and stall control
module id_ex_latch
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dmem_busy,
  input  logic             flush_ls,
  input  logic             flush_br,
  input  logic             id_valid,
  input  opcode_t          id_op,
  input  funct_t           id_funct,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  regbits_t         id_wsel,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_halt,
  input  word_t            id_imm,
  input  word_t            id_rdat1,
  input  word_t            id_rdat2,
  input  word_t            id_npc,
  output logic             ex_valid,
  output opcode_t          ex_op,
  output funct_t           ex_funct,
  output regbits_t         ex_rs,
  output regbits_t         ex_rt,
  output regbits_t         ex_wsel,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_halt,
  output word_t            ex_imm,
  output word_t            ex_rdat1,
  output word_t            ex_rdat2,
  output word_t            ex_npc,
  output logic             id_stall,
  output logic [CNT_W-1:0] ls_bubbles,
  output logic [CNT_W-1:0] br_flushes
);

  id_ex_t r, r_next;
  logic   br_inc, ls_inc;

  // A branch squashes ID outright, so only a lone load-use bubble freezes IF/ID
  assign id_stall = dmem_busy | (flush_ls & ~flush_br);

  always_comb begin
    r_next = r;
    br_inc = 1'b0;
    ls_inc = 1'b0;
    if (dmem_busy) begin
      r_next = r;
    end else if (flush_br) begin
      r_next = ID_EX_BUBBLE;
      br_inc = 1'b1;
    end else if (flush_ls) begin
      r_next = ID_EX_BUBBLE;
      ls_inc = 1'b1;
    end else if (!ihit) begin
      r_next = ID_EX_BUBBLE;
    end else begin
      r_next.valid    = id_valid;
      r_next.op       = id_op;
      r_next.funct    = id_funct;
      r_next.rs       = id_rs;
      r_next.rt       = id_rt;
      r_next.wsel     = id_wsel;
      r_next.regwrite = id_regwrite;
      r_next.memread  = id_memread;
      r_next.memwrite = id_memwrite;
      r_next.halt     = id_halt;
      r_next.imm      = id_imm;
      r_next.rdat1    = id_rdat1;
      r_next.rdat2    = id_rdat2;
      r_next.npc      = id_npc;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST)
      r <= ID_EX_BUBBLE;
    else
      r <= r_next;
  end

  assign ex_valid    = r.valid;
  assign ex_op       = r.op;
  assign ex_funct    = r.funct;
  assign ex_rs       = r.rs;
  assign ex_rt       = r.rt;
  assign ex_wsel     = r.wsel;
  assign ex_regwrite = r.regwrite;
  assign ex_memread  = r.memread;
  assign ex_memwrite = r.memwrite;
  assign ex_halt     = r.halt;
  assign ex_imm      = r.imm;
  assign ex_rdat1    = r.rdat1;
  assign ex_rdat2    = r.rdat2;
  assign ex_npc      = r.npc;

  sat_counter #(.W(CNT_W)) u_ls_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (ls_inc),
    .count (ls_bubbles)
  );

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (br_inc),
    .count (br_flushes)
  );

endmodule
